// File: rtl/data_memory_responder_pkg.sv
// data_memory_pkg: shared types and constants for the data-memory responder.
//   state_e     : responder FSM states (IDLE/BUSY/DONE)
//   size_e      : decoded load size (word/half/byte)
//   WORD_W      : data word width
//   CNT_W       : wait-counter width (LATENCY up to 15)
//   decode_size : readByte/readHalf flags -> size_e (byte wins over half)
package data_memory_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_e;

  function automatic size_e decode_size(input logic read_byte, input logic read_half);
    if (read_byte) return SZ_BYTE;
    if (read_half) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: CPU MEM-stage <-> data-memory request bus.
//   master : CPU side, drives the request, observes dataOut/success
//   slave  : responder side
interface data_memory_responder_if
  import data_memory_pkg::*;
  ;
  logic              readEnable;
  logic              writeEnable;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] dataIn;
  logic              readByte;
  logic              readHalf;
  logic              readUnsigned;
  logic [WORD_W-1:0] dataOut;
  logic              success;

  modport master (
    output readEnable, writeEnable, address, dataIn,
           readByte, readHalf, readUnsigned,
    input  dataOut, success
  );

  modport slave (
    input  readEnable, writeEnable, address, dataIn,
           readByte, readHalf, readUnsigned,
    output dataOut, success
  );
endinterface

// File: rtl/data_memory_responder_load_extractor.sv
// load_extractor: combinational lane select and sign/zero extension of a
// loaded word.
//   i_word     : full RAM word
//   i_lane     : byte address bits [1:0]
//   i_size     : decoded load size
//   i_unsigned : zero-extend instead of sign-extend (byte/half only)
//   o_data     : extended result
module load_extractor
  import data_memory_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  size_e             i_size,
  input  logic              i_unsigned,
  output logic [WORD_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = '0;
    w_half = '0;
    o_data = i_word;
    unique case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = '0;
    endcase
    // Half lane uses bit 1 only; a misaligned half folds onto its aligned lane.
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    unique case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: responder end of the CPU data-memory port.
// Latches a load/store request in IDLE, waits LATENCY cycles in BUSY,
// performs the RAM access on the last BUSY cycle, and spends one cycle
// in DONE with success high before returning to IDLE.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : request/response bus (slave modport)
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [AW+1:0]      r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic               r_rd;
  logic               r_wr;
  size_e              r_size;
  logic               r_unsigned;
  logic [WORD_W-1:0]  r_dout;
  logic [WORD_W-1:0]  r_mem [DEPTH_WORDS];

  logic               w_access;
  logic [AW-1:0]      w_idx;
  logic [WORD_W-1:0]  w_word;
  logic [WORD_W-1:0]  w_load;
  logic               w_success;

  assign w_access = (r_state == BUSY) && (r_count == CNT_W'(1));
  assign w_idx    = r_addr[AW+1:2];
  assign w_word   = r_mem[w_idx];

  load_extractor u_extract (
    .i_word     (w_word),
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load)
  );

  always_comb begin
    w_success = 1'b1;
    unique case (r_state)
      IDLE:    w_success = ~(bus.readEnable | bus.writeEnable);
      BUSY:    w_success = 1'b0;
      default: w_success = 1'b1;
    endcase
  end

  assign bus.success = w_success;
  assign bus.dataOut = r_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_size     <= SZ_WORD;
      r_unsigned <= 1'b0;
      r_dout     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.readEnable | bus.writeEnable) begin
            r_addr     <= bus.address[AW+1:0];
            r_wdata    <= bus.dataIn;
            r_rd       <= bus.readEnable;
            r_wr       <= bus.writeEnable;
            r_size     <= decode_size(bus.readByte, bus.readHalf);
            r_unsigned <= bus.readUnsigned;
            r_count    <= CNT_W'(LATENCY);
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (r_count == CNT_W'(1)) begin
            // w_load sees the pre-write word, so read+write returns old data.
            if (r_rd) r_dout <= w_load;
            r_state <= DONE;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // No reset on the array; an async reset forces IDLE, which blocks w_access.
  always_ff @(posedge clk) begin
    if (w_access && r_wr) r_mem[w_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic clk;
  logic rst;

  data_memory_responder_if bus ();

  data_memory_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: memory image and last load result.
  logic [31:0] mmem [DEPTH];
  logic [31:0] model_dout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input bit rb, input bit rh, input bit ru);
    int unsigned v;
    int unsigned sh;
    if (rb) begin
      sh = 8 * int'(a);
      v  = (w >> sh) & 32'hFF;
      if (!ru && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (rh) begin
      sh = 16 * int'(a[1]);
      v  = (w >> sh) & 32'hFFFF;
      if (!ru && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic clear_req();
    bus.readEnable   = 1'b0;
    bus.writeEnable  = 1'b0;
    bus.address      = '0;
    bus.dataIn       = '0;
    bus.readByte     = 1'b0;
    bus.readHalf     = 1'b0;
    bus.readUnsigned = 1'b0;
  endtask

  // Drives one request and follows it to completion. hold keeps the inputs
  // asserted past DONE; drop releases them after the first BUSY cycle.
  task automatic run_req(input string tag, input bit re, input bit we,
                         input logic [31:0] addr, input logic [31:0] din,
                         input bit rb, input bit rh, input bit ru,
                         input bit hold, input bit drop);
    int          lows;
    int unsigned idx;
    logic [31:0] pre;
    bus.readEnable   = re;
    bus.writeEnable  = we;
    bus.address      = addr;
    bus.dataIn       = din;
    bus.readByte     = rb;
    bus.readHalf     = rh;
    bus.readUnsigned = ru;
    idx = (addr >> 2) % DEPTH;
    pre = mmem[idx];
    lows = 0;
    #1;
    while (bus.success !== 1'b1 && lows < 40) begin
      @(negedge clk);
      lows++;
      if (drop && lows == 1) clear_req();
      #1;
    end
    check_eq({tag, "_lowcycles"}, lows, LATENCY + 1);
    if (re) model_dout = ref_load(pre, addr[1:0], rb, rh, ru);
    if (we) mmem[idx] = din;
    check_eq({tag, "_dout"}, bus.dataOut, model_dout);
    if (!hold) clear_req();
    @(negedge clk);
    if (!hold) begin
      #1;
      check_eq({tag, "_idle"}, bus.success, 1'b1);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int unsigned kind;
    bit rb, rh, ru, re, we;

    model_dout = '0;
    clear_req();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_success", bus.success, 1'b1);
    check_eq("rst_dout", bus.dataOut, 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_success", bus.success, 1'b1);
      check_eq("idle_dout", bus.dataOut, 32'h0);
    end

    run_req("st100", 0, 1, 32'h100, 32'h8badf00d, 0, 0, 0, 0, 0);
    run_req("ldw100", 1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);
    check_eq("ldw100_const", bus.dataOut, 32'h8badf00d);

    run_req("st20", 0, 1, 32'h20, 32'h80ff7f01, 0, 0, 0, 0, 0);
    run_req("lb20", 1, 0, 32'h20, 32'h0, 1, 0, 0, 0, 0);
    run_req("lb21", 1, 0, 32'h21, 32'h0, 1, 0, 0, 0, 0);
    run_req("lb23", 1, 0, 32'h23, 32'h0, 1, 0, 0, 0, 0);
    check_eq("lb23_const", bus.dataOut, 32'hffffff80);
    run_req("lbu22", 1, 0, 32'h22, 32'h0, 1, 0, 1, 0, 0);
    run_req("lh22", 1, 0, 32'h22, 32'h0, 0, 1, 0, 0, 0);
    check_eq("lh22_const", bus.dataOut, 32'hffff80ff);
    run_req("lhu22", 1, 0, 32'h22, 32'h0, 0, 1, 1, 0, 0);
    run_req("lh23", 1, 0, 32'h23, 32'h0, 0, 1, 0, 0, 0);
    run_req("lbh20", 1, 0, 32'h21, 32'h0, 1, 1, 0, 0, 0);

    // Two identical loads with inputs held: two separate service windows.
    run_req("b2b_1", 1, 0, 32'h100, 32'h0, 0, 0, 0, 1, 0);
    run_req("b2b_2", 1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);

    // Read+write together returns pre-write contents.
    run_req("rw100", 1, 1, 32'h102, 32'h11223344, 0, 1, 0, 0, 0);
    run_req("ld100b", 1, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);

    // Reset in the second BUSY cycle aborts the store.
    run_req("st40", 0, 1, 32'h40, 32'hcafebabe, 0, 0, 0, 0, 0);
    bus.writeEnable = 1'b1;
    bus.address     = 32'h40;
    bus.dataIn      = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("abort_busy", bus.success, 1'b0);
    rst = 1'b0;
    clear_req();
    #1;
    check_eq("abort_success", bus.success, 1'b1);
    check_eq("abort_dout", bus.dataOut, 32'h0);
    model_dout = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_req("ld40", 1, 0, 32'h40, 32'h0, 0, 0, 0, 0, 0);

    // Request dropped during BUSY still completes.
    run_req("st104drop", 0, 1, 32'h104, 32'h5a5aa5a5, 0, 0, 0, 0, 1);
    run_req("ld104", 1, 0, 32'h104, 32'h0, 0, 0, 0, 0, 0);

    // Upper address bits wrap onto the same word.
    run_req("ldwrap", 1, 0, 32'hABCD_E104, 32'h0, 0, 0, 0, 0, 0);

    // Random phase over a prefilled 32-word window.
    for (int i = 0; i < 32; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2) | 32'($urandom_range(0, 3));
      run_req("rnd_fill", 0, 1, a, $urandom, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 60; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2)
          | 32'($urandom_range(0, 3));
      d    = $urandom;
      kind = $urandom_range(0, 3);
      re   = (kind != 0);
      we   = (kind == 0) || (kind == 3);
      rb   = ($urandom_range(0, 2) == 0);
      rh   = ($urandom_range(0, 1) == 0);
      ru   = ($urandom_range(0, 1) == 0);
      run_req("rnd", re, we, a, d, rb, rh, ru, 0, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
